// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter with bounded bus lock in front of the shared peripheral/DataMem port.
// Define ARB_PERF_CNT_EN to add per-master wait-cycle counters (m0_wait_cnt/m1_wait_cnt).
//
// state | meaning
// IDLE  | no lock held; round-robin between requesters, ties go to master != last_gnt
// LOCK0 | M0 owns the bus while it keeps requesting
// LOCK1 | M1 owns the bus while it keeps requesting
module periph_bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 16,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              s_rd,
    output logic              s_wr,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              lock_err
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  m0_wait_cnt,
    output logic [CNT_W-1:0]  m1_wait_cnt
`endif
);

    localparam int LCW = $clog2(MAX_LOCK);
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(MAX_LOCK - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic           last_gnt, last_gnt_nxt;
    logic [LCW-1:0] lock_cnt, lock_cnt_nxt, cnt_base;
    logic           lock_err_nxt;
    logic           gnt0, gnt1, own_lock;

    // Grant is combinational so the CPU can stall on m0_ack in the same cycle.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset) begin
            if (state == LOCK0 && m0_req) begin
                gnt0 = 1'b1;
            end else if (state == LOCK1 && m1_req) begin
                gnt1 = 1'b1;
            end else if (m0_req && m1_req) begin
                gnt0 = last_gnt;
                gnt1 = ~last_gnt;
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end
    end

    always_comb begin
        state_nxt    = IDLE;
        last_gnt_nxt = last_gnt;
        lock_cnt_nxt = '0;
        lock_err_nxt = 1'b0;
        own_lock     = gnt0 ? m0_lock : m1_lock;
        // A new owner starts its locked run from zero.
        cnt_base     = ((state == LOCK0 && gnt0) || (state == LOCK1 && gnt1)) ? lock_cnt : '0;
        if (gnt0 || gnt1) begin
            last_gnt_nxt = gnt1;
            if (own_lock) begin
                if (cnt_base == LOCK_LAST) begin
                    lock_err_nxt = 1'b1;
                end else begin
                    state_nxt    = gnt1 ? LOCK1 : LOCK0;
                    lock_cnt_nxt = cnt_base + LCW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            lock_cnt <= '0;
            lock_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
            lock_cnt <= lock_cnt_nxt;
            lock_err <= lock_err_nxt;
        end
    end

    assign m0_ack   = gnt0;
    assign m1_ack   = gnt1;
    assign s_rd     = (gnt0 & ~m0_wr) | (gnt1 & ~m1_wr);
    assign s_wr     = (gnt0 & m0_wr) | (gnt1 & m1_wr);
    assign s_addr   = gnt0 ? m0_addr : (gnt1 ? m1_addr : '0);
    assign s_wdata  = gnt0 ? m0_wdata : (gnt1 ? m1_wdata : '0);
    assign m0_rdata = (gnt0 & ~m0_wr) ? s_rdata : '0;
    assign m1_rdata = (gnt1 & ~m1_wr) ? s_rdata : '0;

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m0_wait_cnt <= '0;
            m1_wait_cnt <= '0;
        end else begin
            if (m0_req && !gnt0 && !(&m0_wait_cnt)) m0_wait_cnt <= m0_wait_cnt + CNT_W'(1);
            if (m1_req && !gnt1 && !(&m1_wait_cnt)) m1_wait_cnt <= m1_wait_cnt + CNT_W'(1);
        end
    end
`else
    wire [CNT_W-1:0] unused_cnt_w = '0;
`endif

endmodule
